// File: rtl/rv32i_ctrl_unit.sv
// Multi-cycle RV32I control unit: fetch over req/valid, decode to cword/imm, hold for the datapath, update pc.
// Optional feature macro: ILLEGAL_INSN_TRAP_EN (unknown opcode halts until reset).
module rv32i_ctrl_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned EXEC_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  input  logic        br_taken,
  input  logic [31:0] r_for_pc,
  output logic [22:0] cword,
  output logic [31:0] pc,
  output logic [31:0] imm,
  output logic        insn_done,
  output logic        halt
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CW_W  = 23;
  localparam int unsigned CNT_W = 4;
  localparam logic [CW_W-1:0]  NOP_CWORD = 23'h000001;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(EXEC_CYCLES - 1);

  localparam logic [6:0] OP_LOAD  = 7'h03;
  localparam logic [6:0] OP_IMM   = 7'h13;
  localparam logic [6:0] OP_STORE = 7'h23;
  localparam logic [6:0] OP_REG   = 7'h33;
  localparam logic [6:0] OP_LUI   = 7'h37;
  localparam logic [6:0] OP_AUIPC = 7'h17;
  localparam logic [6:0] OP_BRNCH = 7'h63;
  localparam logic [6:0] OP_JALR  = 7'h67;
  localparam logic [6:0] OP_JAL   = 7'h6F;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_PCUPD
`ifdef ILLEGAL_INSN_TRAP_EN
    , S_HALT
`endif
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [XLEN-1:0]   r_pc, w_pc_nxt, r_npc, w_npc_nxt, r_insn, w_insn_nxt;
  logic [XLEN-1:0]   r_imm, w_imm_nxt;
  logic [CW_W-1:0]   r_cword, w_cword_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic              r_req, w_req_nxt, r_done, w_done_nxt;
`ifdef ILLEGAL_INSN_TRAP_EN
  logic              r_halt, w_halt_nxt;
`endif

  logic [XLEN-1:0]   w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  logic [XLEN-1:0]   w_dec_imm, w_target, w_next_pc;
  logic [CW_W-1:0]   w_dec_cword;
  logic [4:0]        w_rd, w_rs1, w_rs2;
  logic [3:0]        w_type;
  logic [2:0]        w_f3;
  logic              w_f7, w_known;

  assign w_imm_i = {{20{r_insn[31]}}, r_insn[31:20]};
  assign w_imm_s = {{20{r_insn[31]}}, r_insn[31:25], r_insn[11:7]};
  assign w_imm_b = {{19{r_insn[31]}}, r_insn[31], r_insn[7], r_insn[30:25], r_insn[11:8], 1'b0};
  assign w_imm_u = {r_insn[31:12], 12'b0};
  assign w_imm_j = {{11{r_insn[31]}}, r_insn[31], r_insn[19:12], r_insn[20], r_insn[30:21], 1'b0};

  // Instruction decode of the latched fetch word; unknown opcodes collapse to NOP.
  always_comb begin
    w_known   = 1'b1;
    w_type    = 4'd1;
    w_rd      = 5'd0;
    w_rs1     = 5'd0;
    w_rs2     = 5'd0;
    w_f3      = 3'd0;
    w_f7      = 1'b0;
    w_dec_imm = '0;
    case (r_insn[6:0])
      OP_LOAD:  begin w_type = 4'd0; w_rd = r_insn[11:7]; w_rs1 = r_insn[19:15]; w_f3 = r_insn[14:12]; w_dec_imm = w_imm_i; end
      OP_IMM:   begin
        w_type = 4'd1; w_rd = r_insn[11:7]; w_rs1 = r_insn[19:15]; w_f3 = r_insn[14:12]; w_dec_imm = w_imm_i;
        w_f7   = (r_insn[14:12] == 3'b101) ? r_insn[30] : 1'b0;
      end
      OP_STORE: begin w_type = 4'd2; w_rs1 = r_insn[19:15]; w_rs2 = r_insn[24:20]; w_f3 = r_insn[14:12]; w_dec_imm = w_imm_s; end
      OP_REG:   begin
        w_type = 4'd3; w_rd = r_insn[11:7]; w_rs1 = r_insn[19:15]; w_rs2 = r_insn[24:20];
        w_f3   = r_insn[14:12]; w_f7 = r_insn[30];
      end
      OP_LUI:   begin w_type = 4'd4; w_rd = r_insn[11:7]; w_dec_imm = w_imm_u; end
      OP_AUIPC: begin w_type = 4'd5; w_rd = r_insn[11:7]; w_dec_imm = w_imm_u; end
      OP_BRNCH: begin w_type = 4'd6; w_rs1 = r_insn[19:15]; w_rs2 = r_insn[24:20]; w_f3 = r_insn[14:12]; w_dec_imm = w_imm_b; end
      OP_JALR:  begin w_type = 4'd7; w_rd = r_insn[11:7]; w_rs1 = r_insn[19:15]; w_dec_imm = w_imm_i; end
      OP_JAL:   begin w_type = 4'd8; w_rd = r_insn[11:7]; w_dec_imm = w_imm_j; end
      default:  w_known = 1'b0;
    endcase
    w_dec_cword = w_known ? {w_rs2, w_rs1, w_rd, w_f7, w_f3, w_type} : NOP_CWORD;
  end

  // Next-pc from the held control word; low two bits always cleared.
  always_comb begin
    w_target = r_pc + 32'd4;
    case (r_cword[3:0])
      4'd6:    if (br_taken) w_target = r_pc + r_imm;
      4'd7:    w_target = r_for_pc + r_imm;
      4'd8:    w_target = r_pc + r_imm;
      default: w_target = r_pc + 32'd4;
    endcase
    w_next_pc = w_target & ~32'd3;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_npc_nxt   = r_npc;
    w_insn_nxt  = r_insn;
    w_cword_nxt = r_cword;
    w_imm_nxt   = r_imm;
    w_cnt_nxt   = r_cnt;
    w_req_nxt   = 1'b0;
    w_done_nxt  = 1'b0;
`ifdef ILLEGAL_INSN_TRAP_EN
    w_halt_nxt  = r_halt;
`endif
    case (r_state)
      S_FETCH: begin
        if (r_req && imem_valid) begin
          w_insn_nxt  = imem_rdata;
          w_state_nxt = S_DECODE;
        end else begin
          w_req_nxt = 1'b1;
        end
      end
      S_DECODE: begin
        w_cword_nxt = w_dec_cword;
        w_imm_nxt   = w_dec_imm;
        w_cnt_nxt   = '0;
        w_state_nxt = S_EXEC;
`ifdef ILLEGAL_INSN_TRAP_EN
        if (!w_known) begin
          w_cword_nxt = NOP_CWORD;
          w_halt_nxt  = 1'b1;
          w_state_nxt = S_HALT;
        end
`endif
      end
      S_EXEC: begin
        if (r_cnt == CNT_LAST) begin
          w_npc_nxt   = w_next_pc;
          w_cword_nxt = NOP_CWORD;
          w_done_nxt  = 1'b1;
          w_state_nxt = S_PCUPD;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_PCUPD: begin
        w_pc_nxt    = r_npc;
        w_req_nxt   = 1'b1;
        w_state_nxt = S_FETCH;
      end
      default: w_state_nxt = r_state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_FETCH;
      r_pc    <= RESET_PC;
      r_npc   <= RESET_PC;
      r_insn  <= '0;
      r_cword <= NOP_CWORD;
      r_imm   <= '0;
      r_cnt   <= '0;
      r_req   <= 1'b0;
      r_done  <= 1'b0;
`ifdef ILLEGAL_INSN_TRAP_EN
      r_halt  <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_npc   <= w_npc_nxt;
      r_insn  <= w_insn_nxt;
      r_cword <= w_cword_nxt;
      r_imm   <= w_imm_nxt;
      r_cnt   <= w_cnt_nxt;
      r_req   <= w_req_nxt;
      r_done  <= w_done_nxt;
`ifdef ILLEGAL_INSN_TRAP_EN
      r_halt  <= w_halt_nxt;
`endif
    end
  end

  assign imem_req  = r_req;
  assign imem_addr = r_pc;
  assign pc        = r_pc;
  assign cword     = r_cword;
  assign imm       = r_imm;
  assign insn_done = r_done;
`ifdef ILLEGAL_INSN_TRAP_EN
  assign halt      = r_halt;
`else
  assign halt      = 1'b0;
`endif

endmodule

// File: tb/tb_rv32i_ctrl_unit.sv
// Scoreboard bench for rv32i_ctrl_unit: an imem driver issues instructions and queues expected results,
// a negedge monitor pops them on insn_done.
module tb_rv32i_ctrl_unit;

  localparam int EXEC_CYCLES = 4;
  localparam int ND          = 10;

  typedef struct packed {
    logic [31:0] pc;
    logic [22:0] cword;
    logic [31:0] imm;
    logic [31:0] npc;
  } exp_t;

  logic        clk, rst, imem_req, imem_valid, br_taken, insn_done, halt;
  logic [31:0] imem_addr, imem_rdata, r_for_pc, pc, imm;
  logic [22:0] cword;

  int          n_tests = 0;
  int          n_fail  = 0;
  exp_t        sb[$];
  logic [31:0] mpc;
  int          cyc = 0;
  int          hs_cyc = 0;
  int          hold = 0;
  bit          in_fl = 0;
  bit          pend = 0;
  logic [31:0] pend_npc;
  logic        prev_req = 0;
  logic [22:0] prev_cword = 23'h1;
  logic [31:0] d_insn [ND];
  logic        d_br   [ND];
  logic [31:0] d_rfp  [ND];
  int          d_wait [ND];

  rv32i_ctrl_unit #(.RESET_PC(32'h0), .EXEC_CYCLES(EXEC_CYCLES)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_valid(imem_valid),
    .imem_rdata(imem_rdata), .br_taken(br_taken), .r_for_pc(r_for_pc), .cword(cword), .pc(pc),
    .imm(imm), .insn_done(insn_done), .halt(halt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required $finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: fields and immediates from opcode rules using plain arithmetic.
  function automatic exp_t model(input logic [31:0] cpc, input logic [31:0] insn,
                                 input logic br, input logic [31:0] rfp);
    exp_t        e;
    int          s, ty, f7, cw;
    logic [31:0] im, tgt;
    bit          h_rd, h_rs1, h_rs2, h_f3;
    s = int'($signed(insn));
    ty = -1; im = 32'h0; h_rd = 0; h_rs1 = 0; h_rs2 = 0; h_f3 = 0;
    case (insn[6:0])
      7'h03: begin ty = 0; h_rd = 1; h_rs1 = 1; h_f3 = 1; im = 32'(s >>> 20); end
      7'h13: begin ty = 1; h_rd = 1; h_rs1 = 1; h_f3 = 1; im = 32'(s >>> 20); end
      7'h23: begin ty = 2; h_rs1 = 1; h_rs2 = 1; h_f3 = 1; im = 32'((s >>> 25) * 32 + int'(insn[11:7])); end
      7'h33: begin ty = 3; h_rd = 1; h_rs1 = 1; h_rs2 = 1; h_f3 = 1; end
      7'h37: begin ty = 4; h_rd = 1; im = insn & 32'hFFFF_F000; end
      7'h17: begin ty = 5; h_rd = 1; im = insn & 32'hFFFF_F000; end
      7'h63: begin
        ty = 6; h_rs1 = 1; h_rs2 = 1; h_f3 = 1;
        im = 32'((s >>> 31) * 4096 + int'(insn[7]) * 2048 + int'(insn[30:25]) * 32 + int'(insn[11:8]) * 2);
      end
      7'h67: begin ty = 7; h_rd = 1; h_rs1 = 1; im = 32'(s >>> 20); end
      7'h6F: begin
        ty = 8; h_rd = 1;
        im = 32'((s >>> 31) * 1048576 + int'(insn[19:12]) * 4096 + int'(insn[20]) * 2048 + int'(insn[30:21]) * 2);
      end
      default: ty = -1;
    endcase
    f7 = ((ty == 3) || (ty == 1 && insn[14:12] == 3'd5)) ? int'(insn[30]) : 0;
    if (ty < 0) cw = 1;
    else cw = (h_rs2 ? int'(insn[24:20]) : 0) * 262144 + (h_rs1 ? int'(insn[19:15]) : 0) * 8192
            + (h_rd ? int'(insn[11:7]) : 0) * 256 + f7 * 128 + (h_f3 ? int'(insn[14:12]) : 0) * 16 + ty;
    if (ty == 8 || (ty == 6 && br)) tgt = cpc + im;
    else if (ty == 7) tgt = rfp + im;
    else tgt = cpc + 32'd4;
    e.pc = cpc; e.cword = 23'(cw); e.imm = im; e.npc = tgt & ~32'd3;
    return e;
  endfunction

  function automatic logic [31:0] gen_insn();
    logic [31:0] r = $urandom;
    int          sel;
    logic [6:0]  op;
`ifdef ILLEGAL_INSN_TRAP_EN
    sel = int'($urandom_range(0, 8));
`else
    sel = int'($urandom_range(0, 9));
`endif
    case (sel)
      0: op = 7'h03; 1: op = 7'h13; 2: op = 7'h23; 3: op = 7'h33; 4: op = 7'h37;
      5: op = 7'h17; 6: op = 7'h63; 7: op = 7'h67; 8: op = 7'h6F;
      default: case ($urandom_range(0, 3))
        0: op = 7'h0B; 1: op = 7'h2B; 2: op = 7'h5B; default: op = 7'h7F;
      endcase
    endcase
    return {r[31:7], op};
  endfunction

  // Acts as instruction memory for one fetch; junk valid while req is low must be ignored.
  task automatic run_insn(input logic [31:0] insn, input logic br, input logic [31:0] rfp,
                          input int nwait, input bit push);
    int   t = 0;
    exp_t e;
    while (!imem_req && t < 40) begin
      #1 imem_valid = 1'($urandom_range(0, 1)); imem_rdata = $urandom;
      @(negedge clk); t++;
    end
    chk("fetch_req", 32'(imem_req), 32'd1);
    for (int w = 0; w < nwait; w++) begin
      #1 imem_valid = 1'b0;
      @(negedge clk);
      chk("req_held", 32'(imem_req), 32'd1);
      chk("addr_held", imem_addr, mpc);
    end
    chk("fetch_addr", imem_addr, mpc);
    if (push) begin
      e = model(mpc, insn, br, rfp);
      sb.push_back(e);
      mpc = e.npc;
    end
    #1 br_taken = br; r_for_pc = rfp; imem_rdata = insn; imem_valid = 1'b1;
    @(negedge clk);
    #1 imem_valid = 1'b0; imem_rdata = $urandom;
  endtask

  task automatic drain();
    int t = 0;
    while ((sb.size() != 0 || pend) && t < 100) begin
      @(negedge clk); t++;
    end
    chk("drain_queue", 32'(sb.size()), 32'd0);
  endtask

  // Monitor: a falling req marks acceptance (now in DECODE); insn_done pops the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (!rst) begin
      in_fl = 0;
      pend  = 0;
    end else begin
      if (pend) begin
        chk("next_pc", pc, pend_npc);
        chk("done_pulse_width", 32'(insn_done), 32'd0);
        pend = 0;
      end
      if (prev_req && !imem_req) begin
        in_fl = 1; hs_cyc = cyc; hold = 0;
      end
      if (in_fl && sb.size() != 0 && cword == sb[0].cword) hold++;
      if (insn_done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'(insn_done), 32'd0);
        end else begin
          e = sb.pop_front();
          chk("pc_in_flight", pc, e.pc);
          chk("cword", 32'(prev_cword), 32'(e.cword));
          chk("imm", imm, e.imm);
          chk("latency", 32'(cyc - hs_cyc), 32'(EXEC_CYCLES + 1));
          chk("cword_hold", 32'(hold), (e.cword == 23'h1) ? 32'(EXEC_CYCLES + 2) : 32'(EXEC_CYCLES));
          chk("nop_in_pcupd", 32'(cword), 32'h1);
          pend = 1; pend_npc = e.npc; in_fl = 0;
        end
      end
    end
    prev_req   = imem_req;
    prev_cword = cword;
  end

  initial begin
    d_insn = '{32'h00700293, 32'h402081B3, 32'h4030D093, 32'h40000013, 32'h00208463,
               32'h00208463, 32'h00C300E7, 32'h00C300E7, 32'h008000EF, 32'hFFFFFFFF};
    d_br   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    d_rfp  = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h101, 32'hFFFFFFF0, 32'h0, 32'h0};
    d_wait = '{5, 0, 1, 0, 0, 2, 0, 0, 0, 5};
    rst = 1'b0; imem_valid = 1'b0; imem_rdata = 32'h0; br_taken = 1'b0; r_for_pc = 32'h0;
    mpc = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_pc", pc, 32'h0);
    chk("rst_cword", 32'(cword), 32'h1);
    chk("rst_imm", imm, 32'h0);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_halt", 32'(halt), 32'd0);
    chk("rst_done", 32'(insn_done), 32'd0);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("req_after_rst", 32'(imem_req), 32'd1);
    chk("addr_after_rst", imem_addr, 32'h0);

    for (int i = 0; i < ND; i++) begin
`ifdef ILLEGAL_INSN_TRAP_EN
      if (d_insn[i][6:0] == 7'h7F) continue;
`endif
      run_insn(d_insn[i], d_br[i], d_rfp[i], d_wait[i], 1'b1);
    end
    for (int i = 0; i < 120; i++) begin
      run_insn(gen_insn(), 1'($urandom_range(0, 1)), $urandom,
               ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 5)) : 0, 1'b1);
    end
    drain();
    chk("halt_idle", 32'(halt), 32'd0);

    // Abort an instruction mid-EXEC with reset.
    run_insn(32'h00700293, 1'b0, 32'h0, 0, 1'b1);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midexec_rst_cword", 32'(cword), 32'h1);
    chk("midexec_rst_pc", pc, 32'h0);
    chk("midexec_rst_req", 32'(imem_req), 32'd0);
    sb.delete();
    mpc = 32'h0;
    #1 rst = 1'b1;
    run_insn(32'h0140006F, 1'b0, 32'h0, 0, 1'b1);
    run_insn(gen_insn(), 1'b1, $urandom, 0, 1'b1);
    drain();

`ifdef ILLEGAL_INSN_TRAP_EN
    run_insn(32'hFFFFFFFF, 1'b0, 32'h0, 0, 1'b0);
    repeat (8) @(negedge clk);
    chk("trap_halt", 32'(halt), 32'd1);
    chk("trap_req", 32'(imem_req), 32'd0);
    chk("trap_cword", 32'(cword), 32'h1);
    chk("trap_pc", pc, mpc);
    chk("trap_no_done", 32'(sb.size()), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
